// File: rtl/mips_fetch_decode.sv
// +----------------------------------------------------------------------------+
// | mips_fetch_decode: PC, req/ack instruction fetch and decode feeding the     |
// | single-cycle mips32 datapath. Optional macro: ILLEGAL_TRAP_EN.              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module mips_fetch_decode #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        branch_result,
  output logic [4:0]  rsaddr,
  output logic [4:0]  rtaddr,
  output logic [4:0]  rt_rd_chosen,
  output logic [31:0] shiftImm,
  output logic [31:0] S_ZextendImm,
  output logic        shift_select,
  output logic        slt_select,
  output logic        immediate_res,
  output logic [2:0]  alubits,
  output logic        reg_write,
  output logic        memread,
  output logic        memwrite,
  output logic        alu_mem,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic [31:0] pc
`ifdef ILLEGAL_TRAP_EN
  ,output logic       illegal_op
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_BLT  = 6'h01, OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D, OP_LW   = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_ADD = 6'h20, FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR  = 6'h25, FN_SLT = 6'h2A;
  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110, ALU_SLL = 3'b011, ALU_SRL = 3'b100;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic        run_q, run_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        fetch_err_q, fetch_err_d;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal_q, illegal_d;
  logic        op_legal;
`endif

  logic [5:0]  opcode, funct;
  logic [2:0]  dec_alu;
  logic        dec_shift, dec_slt, dec_imm, dec_rw, dec_mr, dec_mw, dec_am, dec_sext;
  logic        in_exec;
  logic [31:0] pc_plus4, br_off, pc_exec_next;

  assign opcode  = ir_q[31:26];
  assign funct   = ir_q[5:0];
  assign in_exec = (state_q == S_EXEC);

  always_comb begin
    dec_alu   = ALU_AND;
    dec_shift = 1'b0;
    dec_slt   = 1'b0;
    dec_imm   = 1'b0;
    dec_rw    = 1'b0;
    dec_mr    = 1'b0;
    dec_mw    = 1'b0;
    dec_am    = 1'b0;
    dec_sext  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_rw = 1'b1;
        case (funct)
          FN_ADD: dec_alu = ALU_ADD;
          FN_SUB: dec_alu = ALU_SUB;
          FN_AND: dec_alu = ALU_AND;
          FN_OR:  dec_alu = ALU_OR;
          FN_SLT: begin dec_alu = ALU_SUB; dec_slt   = 1'b1; end
          FN_SLL: begin dec_alu = ALU_SLL; dec_shift = 1'b1; end
          FN_SRL: begin dec_alu = ALU_SRL; dec_shift = 1'b1; end
          default: dec_rw = 1'b0;
        endcase
      end
      OP_ADDI: begin dec_alu = ALU_ADD; dec_imm = 1'b1; dec_rw = 1'b1; dec_sext = 1'b1; end
      OP_SLTI: begin
        dec_alu = ALU_SUB; dec_slt = 1'b1; dec_imm = 1'b1; dec_rw = 1'b1; dec_sext = 1'b1;
      end
      OP_ANDI: begin dec_alu = ALU_AND; dec_imm = 1'b1; dec_rw = 1'b1; end
      OP_ORI:  begin dec_alu = ALU_OR;  dec_imm = 1'b1; dec_rw = 1'b1; end
      OP_LW: begin
        dec_alu = ALU_ADD; dec_imm = 1'b1; dec_mr = 1'b1; dec_am = 1'b1;
        dec_rw  = 1'b1;    dec_sext = 1'b1;
      end
      OP_SW:  begin dec_alu = ALU_ADD; dec_imm = 1'b1; dec_mw = 1'b1; dec_sext = 1'b1; end
      OP_BLT: dec_alu = ALU_SUB;
      OP_J:   ;
      default: ;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  // Every recognised encoding writes something or is a control transfer.
  assign op_legal = dec_rw | dec_mw | (opcode == OP_BLT) | (opcode == OP_J);
`endif

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  always_comb begin
    pc_exec_next = pc_plus4;
    if (opcode == OP_J)
      pc_exec_next = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    else if ((opcode == OP_BLT) && branch_result)
      pc_exec_next = pc_plus4 + br_off;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ir_valid_d  = ir_valid_q;
    run_d       = 1'b1;
    wait_cnt_d  = wait_cnt_q;
    fetch_err_d = fetch_err_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d   = illegal_q;
`endif
    case (state_q)
      S_FETCH: begin
        // The first cycle after reset release only arms the request.
        if (run_q) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          ir_d       = imem_data;
          ir_valid_d = 1'b1;
          state_d    = S_EXEC;
        end else if (IMEM_TIMEOUT != 0) begin
          if (wait_cnt_q == IMEM_TIMEOUT - 32'd1) begin
            fetch_err_d = 1'b1;
            state_d     = S_HALT;
          end else begin
            wait_cnt_d = wait_cnt_q + 32'd1;
          end
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
        if (!op_legal) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          pc_d = pc_exec_next;
        end
`else
        pc_d = pc_exec_next;
`endif
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      run_q       <= 1'b0;
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      run_q       <= run_d;
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign imem_req     = run_q & ((state_q == S_FETCH) | (state_q == S_WAIT));
  assign instr_valid  = in_exec;
  assign fetch_err    = fetch_err_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_op   = illegal_q;
`endif

  assign rsaddr       = ir_q[25:21];
  assign rtaddr       = ir_q[20:16];
  assign rt_rd_chosen = (opcode == OP_RTYPE) ? ir_q[15:11] : ir_q[20:16];
  assign shiftImm     = {27'd0, ir_q[10:6]};
  assign S_ZextendImm = dec_sext ? {{16{ir_q[15]}}, ir_q[15:0]} : {16'd0, ir_q[15:0]};

  // Selects follow the last captured word; the cleared IR after reset must not decode as sll.
  assign shift_select  = dec_shift & ir_valid_q;
  assign slt_select    = dec_slt & ir_valid_q;
  assign immediate_res = dec_imm & ir_valid_q;
  assign alubits       = ir_valid_q ? dec_alu : 3'b000;
  assign alu_mem       = dec_am & ir_valid_q;
  assign reg_write     = dec_rw & in_exec;
  assign memread       = dec_mr & in_exec;
  assign memwrite      = dec_mw & in_exec;

endmodule

`default_nettype wire
